// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and oversampling constants used by
// the receiver (and later the transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both stages
// reset to 1 so a released reset never looks like a falling edge.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, LSB first, one word per frame with a done strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int SB_TICK = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ticks,
    input  logic              rx,
    output logic [N_BITS-1:0] dout,
    output logic              rx_done,
    output logic              frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int            NW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(N_BITS - 1);
    localparam logic [3:0]    S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0]    S_BIT  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

    uart_state_e       state_r, state_nxt_s;
    logic [3:0]        s_r, s_nxt_s;
    logic [NW-1:0]     n_r, n_nxt_s;
    logic [N_BITS-1:0] shreg_r, shreg_nxt_s;
    logic [N_BITS-1:0] dout_r, dout_nxt_s;
    logic              done_r, done_nxt_s;
    logic              ferr_r, ferr_nxt_s;
    logic              rx_s;

`ifdef UART_RX_PARITY_EN
    logic              par_r, par_nxt_s;
    logic              perr_r, perr_nxt_s;

    // Even parity: the data bits and the parity bit must XOR to zero.
    function automatic logic parity_fail(input logic [N_BITS-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction
`endif

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state and datapath decisions; counters only move on a tick.
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        n_nxt_s     = n_r;
        shreg_nxt_s = shreg_r;
        dout_nxt_s  = dout_r;
        done_nxt_s  = 1'b0;
        ferr_nxt_s  = ferr_r;
`ifdef UART_RX_PARITY_EN
        par_nxt_s   = par_r;
        perr_nxt_s  = perr_r;
`endif
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = START;
                    s_nxt_s     = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (ticks) begin
                    if (s_r == S_MID) begin
                        s_nxt_s = 4'd0;
                        if (!rx_s) begin
                            state_nxt_s = DATA;
                            n_nxt_s     = {NW{1'b0}};
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        s_nxt_s = s_r + 4'd1;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end
            DATA: begin
                if (ticks) begin
                    if (s_r == S_BIT) begin
                        s_nxt_s     = 4'd0;
                        shreg_nxt_s = {rx_s, shreg_r[N_BITS-1:1]};
                        if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt_s = PARITY;
`else
                            state_nxt_s = STOP;
`endif
                        end else begin
                            n_nxt_s = n_r + NW'(1);
                        end
                    end else begin
                        s_nxt_s = s_r + 4'd1;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (ticks) begin
                    if (s_r == S_BIT) begin
                        s_nxt_s     = 4'd0;
                        par_nxt_s   = rx_s;
                        state_nxt_s = STOP;
                    end else begin
                        s_nxt_s = s_r + 4'd1;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end
`endif
            STOP: begin
                if (ticks) begin
                    if (s_r == S_STOP) begin
                        s_nxt_s     = 4'd0;
                        dout_nxt_s  = shreg_r;
                        ferr_nxt_s  = ~rx_s;
                        done_nxt_s  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt_s  = parity_fail(shreg_r, par_r);
`endif
                        state_nxt_s = rx_s ? IDLE : BRK;
                    end else begin
                        s_nxt_s = s_r + 4'd1;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end
            BRK: begin
                // Line held low: wait for it to return high before rearming.
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BRK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                s_nxt_s     = 4'd0;
                n_nxt_s     = {NW{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            s_r     <= 4'd0;
            n_r     <= {NW{1'b0}};
            shreg_r <= {N_BITS{1'b0}};
            dout_r  <= {N_BITS{1'b0}};
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r   <= 1'b0;
            perr_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            s_r     <= s_nxt_s;
            n_r     <= n_nxt_s;
            shreg_r <= shreg_nxt_s;
            dout_r  <= dout_nxt_s;
            done_r  <= done_nxt_s;
            ferr_r  <= ferr_nxt_s;
`ifdef UART_RX_PARITY_EN
            par_r   <= par_nxt_s;
            perr_r  <= perr_nxt_s;
`endif
        end
    end

    assign dout      = dout_r;
    assign rx_done   = done_r;
    assign frame_err = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_r;
`endif

endmodule
